// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
// Hazard, forwarding and bubble tracker for the in-order pipeline.
// Tracks every in-flight instruction from EX (slot 0) to WB (slot NSTAGE-1).
// It raises a load-use stall for the instruction in ID, registers per-operand
// forward selects for EX, and kills younger slots on a taken branch or jump.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   id_valid        ID holds a real instruction
//   id_wen, id_dst  ID instruction register write enable / destination
//   id_lat          slot index whose output first carries the result
//   id_src          NSRC packed source register addresses
//   id_src_rd       per-operand read enable
//   flush           taken branch/jump this cycle
//   stall           combinational: hold PC and ID
//   ex_fwd_sel      registered per-operand select (0 = regfile, k = slot k)
//   slot_valid      registered bubble map
//   perf_stall_cnt  stall cycle counter (PIPE_HAZARD_PERF_EN only, else 0)
//   perf_flush_cnt  flush cycle counter (PIPE_HAZARD_PERF_EN only, else 0)
//
// Optional feature macro: PIPE_HAZARD_PERF_EN
module pipe_hazard_unit #(
    parameter  int unsigned NSTAGE      = 3,
    parameter  int unsigned AW          = 5,
    parameter  int unsigned NSRC        = 2,
    parameter  int unsigned FLUSH_DEPTH = 2,
    localparam int unsigned SELW        = $clog2(NSTAGE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 id_wen,
    input  logic [AW-1:0]        id_dst,
    input  logic [SELW-1:0]      id_lat,
    input  logic [NSRC*AW-1:0]   id_src,
    input  logic [NSRC-1:0]      id_src_rd,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SELW-1:0] ex_fwd_sel,
    output logic [NSTAGE-1:0]    slot_valid,
    output logic [31:0]          perf_stall_cnt,
    output logic [31:0]          perf_flush_cnt
);

    logic [NSTAGE-1:0]    slot_v;
    logic [NSTAGE-1:0]    slot_wen;
    logic [AW-1:0]        slot_dst [NSTAGE];
    logic [SELW-1:0]      slot_lat [NSTAGE];
    logic [NSRC*SELW-1:0] fwd_q;
    logic [NSRC*SELW-1:0] fwd_next;
    logic                 hazard;
    logic                 issue;

    // Scan slots from youngest (0) to oldest; only the first match per
    // operand counts. A producer in slot k sits in slot k+1 once the consumer
    // reaches EX; past the last slot it has been written to the regfile.
    always_comb begin
        logic [AW-1:0]   src;
        logic            found;
        logic [SELW-1:0] pos;
        fwd_next = '0;
        hazard   = 1'b0;
        src      = '0;
        found    = 1'b0;
        pos      = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            src   = id_src[i*AW +: AW];
            found = 1'b0;
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                pos = SELW'(k + 1);
                if (!found && slot_v[k] && slot_wen[k] && (slot_dst[k] == src)
                    && (src != '0) && id_src_rd[i]) begin
                    found = 1'b1;
                    if (k + 1 < NSTAGE) begin
                        if (pos >= slot_lat[k])
                            fwd_next[i*SELW +: SELW] = pos;
                        else
                            hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign stall = id_valid && hazard && !flush;
    assign issue = id_valid && !hazard && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_v <= '0;
            fwd_q  <= '0;
        end else begin
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                slot_v[k]   <= slot_v[k-1];
                slot_wen[k] <= slot_wen[k-1];
                slot_dst[k] <= slot_dst[k-1];
                slot_lat[k] <= slot_lat[k-1];
            end
            slot_v[0]   <= issue;
            slot_wen[0] <= id_wen;
            slot_dst[0] <= id_dst;
            slot_lat[0] <= id_lat;
            // Later assignments win: flush kills the newly shifted young slots.
            if (flush) begin
                for (int unsigned k = 0; k < FLUSH_DEPTH; k++)
                    slot_v[k] <= 1'b0;
            end
            fwd_q <= issue ? fwd_next : '0;
        end
    end

    assign slot_valid = slot_v;
    assign ex_fwd_sel = fwd_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= stall_cnt + 32'd1;
            if (flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard, forwarding and bubble tracker for the in-order pipelined CPU.
- Records the destination register, write-enable and result-ready stage of every in-flight instruction from EX through WB.
- Decides stall (load-use style) for the instruction in ID.
- Produces registered per-operand forward selects for EX.
- Kills younger slots on a taken branch or jump.
- Generalises the fixed EX/MEM/WB stall and forward logic to NSTAGE tracked stages, NSRC source operands and a per-instruction result latency.

Parameters:
- NSTAGE, 3, tracked stages after ID (slot 0 = EX, slot NSTAGE-1 = WB).
- AW, 5, register address width.
- NSRC, 2, source operands per instruction (rs, rt, ...).
- FLUSH_DEPTH, 2, slots killed on flush (slots 0..FLUSH_DEPTH-1); must satisfy 1 <= FLUSH_DEPTH <= NSTAGE.
- SELW (local), clog2(NSTAGE+1), forward-select width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_wen  in  1  ID instruction writes a register.
- id_dst  in  AW  ID destination register.
- id_lat  in  SELW  slot index at whose output the result becomes forwardable (1 = ALU result from MEM, 2 = load data from WB).
- id_src  in  NSRC*AW  source register addresses, operand i in bits [i*AW +: AW].
- id_src_rd  in  NSRC  per-operand read enable.
- flush  in  1  branch/jump taken this cycle.
- stall  out  1  combinational; hold PC and ID.
- ex_fwd_sel  out  NSRC*SELW  registered; 0 = register file, k = forward from output of slot k.
- slot_valid  out  NSTAGE  registered bubble map (1 = real instruction).
- perf_stall_cnt  out  32  see Optional Feature.
- perf_flush_cnt  out  32  see Optional Feature.

Behaviour:
- Slot state per slot: v, wen, dst, lat. Every cycle the slots shift by one: slot k+1 <= slot k. Slot NSTAGE-1 retires.
- Slot 0 load on shift:
  - ID fields when id_valid && !stall && !flush.
  - Otherwise a bubble (v=0, fwd_sel=0).
- Match for operand i: youngest slot k with v && wen && dst==src_i && src_i!=0 && id_src_rd[i].
  - Youngest wins; older matches are ignored.
  - Register 0 never matches.
  - No match: forward select is 0.
- Readiness: when the consumer reaches EX, the producer will be in slot k+1.
  - Ready if k+1 >= lat_k and k+1 <= NSTAGE-1: forward select = k+1.
  - If k+1 > NSTAGE-1 the producer has retired to the register file (written on ~clk): forward select = 0.
  - Not ready: stall=1 for this cycle.
- stall = id_valid && any operand not ready && !flush. Flush overrides stall.
- ex_fwd_sel loads the computed selects together with slot 0. It is valid only while slot_valid[0]=1.
- flush: on the next edge, slots 0..FLUSH_DEPTH-1 become bubbles and the ID instruction is not issued. Older slots shift normally.
- Reset: all v=0, slot_valid=0, ex_fwd_sel=0, stall=0, counters=0. Reset mid-operation discards all in-flight state in one cycle.
- Latency: stall is 0-cycle combinational; ex_fwd_sel and slot_valid are 1 cycle.

Optional Feature:
PIPE_HAZARD_PERF_EN
- Defined:
  - perf_stall_cnt increments each cycle stall=1.
  - perf_flush_cnt increments each cycle flush=1.
  - Both are 32-bit, wrap at 2^32-1 -> 0, and are cleared by rst.
  - Intended for the LCD debug display.
- Undefined: both outputs tied to 0 and no counter flops are synthesised.

Test Plan:
1. ALU producer r3 (lat=1) issued, next cycle consumer reads r3 as operand 0 -> stall=0; next cycle ex_fwd_sel[op0]=1.
2. Load r5 (lat=2), next cycle consumer reads r5 as operand 1 -> stall=1 for exactly 1 cycle, slot_valid[0]=0 bubble; after issue ex_fwd_sel[op1]=2.
3. Producer writes r0 and consumer reads r0 -> stall=0, ex_fwd_sel=0.
4. Two in-flight writers of r7 (slots 0 and 1), consumer reads r7 -> select=1 from the younger writer, never 2.
5. Load-use stall and flush in the same cycle -> stall=0; next cycle slots 0..1 invalid and consumer not issued; with PIPE_HAZARD_PERF_EN, perf_flush_cnt +1 and perf_stall_cnt unchanged.
6. rst asserted with 3 valid slots -> next cycle slot_valid=000, ex_fwd_sel=0, counters 0; first instruction after release issues without stall.
